cam_capture_param: RTL and testbench

Parametrised DVP camera capture block for OV7725-class sensors on Basys3. It assembles 8-bit byte pairs into 16-bit pixels and writes them into a frame buffer. It crops to a configurable active window. It supports RGB565 pass-through, optional byte swap, and YUV422-to-grey conversion into RGB565. It skips a configurable number of start-up frames and reports frame completion, frame count and short-line errors. It sits between the sensor pins and the dual-port frame-buffer BRAM write port.

---
 rtl/cam_capture_param.sv | 202 ++++++++++++++++++++
 tb/tb_cam_capture_param.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_capture_param.sv
// DVP camera capture: pairs sensor bytes into RGB565 (or YUYV->grey) pixels, crops, writes frame buffer.
// Latency: one pclk from the second byte of a pair to the registered write (we/addr/dout).
// Backpressure: none; the frame-buffer write port must accept one write per we cycle.
//
// Ports:
//   pclk, rst          - sensor pixel clock, asynchronous active-high reset
//   vsync, href, d     - DVP sensor inputs (vsync high = blanking, href high = bytes valid)
//   mode               - 0: RGB565 pass-through, 1: YUYV luma to grey RGB565
//   addr, dout, we     - frame-buffer write port
//   frame_done         - one-cycle pulse after a complete frame is stored
//   frame_cnt          - stored frame count (wraps)
//   line_err           - sticky short-line flag, cleared at the next start of frame
module cam_capture_param #(
    parameter int H_ACTIVE    = 320,
    parameter int V_ACTIVE    = 240,
    parameter int ADDR_W      = 17,
    parameter int SKIP_FRAMES = 2,
    parameter int BYTE_SWAP   = 0
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    input  logic              mode,
    output logic [ADDR_W-1:0] addr,
    output logic [15:0]       dout,
    output logic              we,
    output logic              frame_done,
    output logic [7:0]        frame_cnt,
    output logic              line_err
);

    localparam int COL_W  = $clog2(H_ACTIVE + 1);
    localparam int ROW_W  = $clog2(V_ACTIVE + 1);
    localparam int SKIP_W = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;

    localparam logic [COL_W-1:0]  H_MAX    = COL_W'(H_ACTIVE);
    localparam logic [ROW_W-1:0]  V_MAX    = ROW_W'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] H_STEP   = ADDR_W'(H_ACTIVE);
    localparam logic [SKIP_W-1:0] SKIP_MAX = SKIP_W'(SKIP_FRAMES);

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        SKIP     = 2'd1,
        CAPTURE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic              vsync_q, href_q;
    logic              phase_q, phase_d;
    logic [7:0]        b0_q, b0_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       dout_q, dout_d;
    logic              we_q, we_d;
    logic              done_q, done_d;
    logic [7:0]        fcnt_q, fcnt_d;
    logic              lerr_q, lerr_d;

    logic              sof, vrise, hfall, pix_evt, cap;
    logic [COL_W-1:0]  col_v;
    logic [ROW_W-1:0]  row_v;
    logic [ADDR_W-1:0] base_v;
    logic [15:0]       pair, grey;

    assign sof     = vsync_q & ~vsync;
    assign vrise   = ~vsync_q & vsync;
    assign hfall   = href_q & ~href;
    assign pix_evt = href & phase_q;

    // In YUYV the first byte of every pair is luma; replicate it into all three channels.
    assign pair = (BYTE_SWAP != 0) ? {d, b0_q} : {b0_q, d};
    assign grey = {b0_q[7:3], b0_q[7:2], b0_q[7:3]};

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        phase_d = href ? ~phase_q : 1'b0;
        b0_d    = (href && !phase_q) ? d : b0_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        we_d    = 1'b0;
        done_d  = 1'b0;
        fcnt_d  = fcnt_q;
        lerr_d  = lerr_q;
        cap     = (state_q == CAPTURE);
        col_v   = col_q;
        row_v   = row_q;
        base_v  = base_q;

        // Frame sequencing. The *_v copies carry the start-of-frame clear so that a
        // pixel landing on the same edge sees cleared counters.
        case (state_q)
            WAIT_SOF: begin
                if (sof) begin
                    if (skip_q < SKIP_MAX) begin
                        state_d = SKIP;
                    end else begin
                        state_d = CAPTURE;
                        cap     = 1'b1;
                    end
                    col_v  = '0;
                    row_v  = '0;
                    base_v = '0;
                    addr_d = '0;
                    lerr_d = 1'b0;
                end
            end
            SKIP: begin
                if (vrise) begin
                    skip_d  = skip_q + SKIP_W'(1);
                    state_d = WAIT_SOF;
                end
            end
            CAPTURE: begin
                if (vrise) begin
                    state_d = WAIT_SOF;
                    if (row_q == V_MAX) begin
                        done_d = 1'b1;
                        fcnt_d = fcnt_q + 8'd1;
                    end
                end
            end
            default: state_d = WAIT_SOF;
        endcase

        col_d  = col_v;
        row_d  = row_v;
        base_d = base_v;

        if (pix_evt) begin
            if (cap && (row_v < V_MAX) && (col_v < H_MAX)) begin
                we_d   = 1'b1;
                addr_d = base_v + ADDR_W'(col_v);
                dout_d = mode ? grey : pair;
            end
            // Saturate so pixels past the crop window keep being dropped.
            if (col_v < H_MAX) begin
                col_d = col_v + COL_W'(1);
            end
        end

        if (hfall) begin
            if ((state_q == CAPTURE) && (row_v < V_MAX) && (col_v != '0)) begin
                if (col_v < H_MAX) begin
                    lerr_d = 1'b1;
                end
                row_d  = row_v + ROW_W'(1);
                base_d = base_v + H_STEP;
            end
            col_d = '0;
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT_SOF;
            skip_q  <= '0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            phase_q <= 1'b0;
            b0_q    <= '0;
            col_q   <= '0;
            row_q   <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            fcnt_q  <= '0;
            lerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            vsync_q <= vsync;
            href_q  <= href;
            phase_q <= phase_d;
            b0_q    <= b0_d;
            col_q   <= col_d;
            row_q   <= row_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            we_q    <= we_d;
            done_q  <= done_d;
            fcnt_q  <= fcnt_d;
            lerr_q  <= lerr_d;
        end
    end

    assign addr       = addr_q;
    assign dout       = dout_q;
    assign we         = we_q;
    assign frame_done = done_q;
    assign frame_cnt  = fcnt_q;
    assign line_err   = lerr_q;

endmodule

// File: tb/tb_cam_capture_param.sv
`timescale 1ns/1ps
module tb_cam_capture_param;

    localparam int H  = 8;
    localparam int V  = 6;
    localparam int AW = 6;
    localparam int S  = 2;

    logic          pclk = 1'b0;
    logic          rst, vsync, href, mode;
    logic [7:0]    d;
    logic [AW-1:0] addr, addr_s;
    logic [15:0]   dout, dout_s;
    logic          we, we_s, frame_done, fd_s, line_err, le_s;
    logic [7:0]    frame_cnt, fc_s;

    always #5 pclk = ~pclk;

    cam_capture_param #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .SKIP_FRAMES(S), .BYTE_SWAP(0)) dut (
        .pclk(pclk), .rst(rst), .vsync(vsync), .href(href), .d(d), .mode(mode),
        .addr(addr), .dout(dout), .we(we), .frame_done(frame_done),
        .frame_cnt(frame_cnt), .line_err(line_err)
    );

    cam_capture_param #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .SKIP_FRAMES(S), .BYTE_SWAP(1)) dut_sw (
        .pclk(pclk), .rst(rst), .vsync(vsync), .href(href), .d(d), .mode(mode),
        .addr(addr_s), .dout(dout_s), .we(we_s), .frame_done(fd_s),
        .frame_cnt(fc_s), .line_err(le_s)
    );

    int n_cmp, n_bad;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ent(input int a, input logic [15:0] v);
        return (32'(a) << 16) | {16'd0, v};
    endfunction

    // ---------------- observed writes ----------------
    logic [31:0] got_q[$], gots_q[$], exp_q[$], exps_q[$];
    int          got_done, got_done_s;

    always @(negedge pclk) begin
        if (we)         got_q.push_back(ent(int'(addr), dout));
        if (we_s)       gots_q.push_back(ent(int'(addr_s), dout_s));
        if (frame_done) got_done++;
        if (fd_s)       got_done_s++;
    end

    // ---------------- reference model (frame / line / pixel level) ----------------
    int m_skip, m_row, m_col, m_cnt, m_done;
    bit m_cap, m_lerr;

    function automatic logic [15:0] grey565(input logic [7:0] y);
        int r5, g6;
        r5 = int'(y) / 8;
        g6 = int'(y) / 4;
        return 16'(r5 * 2048 + g6 * 32 + r5);
    endfunction

    function automatic void m_pixel(input logic [7:0] b0, input logic [7:0] b1, input logic md);
        if (m_cap && m_row < V && m_col < H) begin
            exp_q.push_back(ent(m_row * H + m_col, md ? grey565(b0) : {b0, b1}));
            exps_q.push_back(ent(m_row * H + m_col, md ? grey565(b0) : {b1, b0}));
        end
        m_col++;
    endfunction

    function automatic void m_line_end();
        if (m_cap && m_row < V) begin
            if (m_col > 0 && m_col < H) m_lerr = 1'b1;
            if (m_col > 0) m_row++;
        end
        m_col = 0;
    endfunction

    function automatic void m_reset();
        m_skip = S; m_row = 0; m_col = 0; m_cnt = 0; m_done = 0;
        m_cap = 1'b0; m_lerr = 1'b0;
    endfunction

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic idle(input int n);
        href = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_pix(input logic [7:0] b0, input logic [7:0] b1, input logic md);
        href = 1'b1; d = b0;
        tick();
        d = b1; mode = md;
        tick();
        m_pixel(b0, b1, md);
    endtask

    task automatic send_line(input int np, input bit odd);
        for (int p = 0; p < np; p++)
            send_pix(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        if (odd) begin
            href = 1'b1; d = 8'($urandom);
            tick();
        end
        idle(2);
        m_line_end();
    endtask

    task automatic do_sof();
        vsync = 1'b0;
        idle(3);
        m_cap = (m_skip == 0); m_row = 0; m_col = 0; m_lerr = 1'b0;
        chk("line_err_at_sof", line_err, m_lerr);
    endtask

    task automatic do_eof();
        int n;
        vsync = 1'b1;
        idle(4);
        if (m_cap) begin
            if (m_row == V) begin
                m_done++;
                m_cnt = (m_cnt + 1) % 256;
            end
        end else begin
            m_skip--;
        end
        m_cap = 1'b0;
        chk("n_writes", got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk("write", got_q[i], exp_q[i]);
        chk("n_writes_swap", gots_q.size(), exps_q.size());
        n = (gots_q.size() < exps_q.size()) ? gots_q.size() : exps_q.size();
        for (int i = 0; i < n; i++) chk("write_swap", gots_q[i], exps_q[i]);
        got_q.delete(); gots_q.delete(); exp_q.delete(); exps_q.delete();
        chk("frame_done_pulses", got_done, m_done);
        chk("frame_done_pulses_swap", got_done_s, m_done);
        chk("frame_cnt", frame_cnt, m_cnt);
        chk("frame_cnt_swap", fc_s, m_cnt);
        chk("line_err", line_err, m_lerr);
        chk("line_err_swap", le_s, m_lerr);
    endtask

    task automatic full_frame();
        do_sof();
        for (int l = 0; l < V; l++) send_line(H, 1'b0);
        do_eof();
    endtask

    task automatic rand_frame();
        int nl;
        do_sof();
        nl = $urandom_range(V - 1, V + 2);
        for (int l = 0; l < nl; l++)
            send_line($urandom_range(0, H + 3), 1'($urandom_range(0, 1)));
        do_eof();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        n_cmp = 0; n_bad = 0;
        got_done = 0; got_done_s = 0;
        m_reset();
        rst = 1'b1; vsync = 1'b1; href = 1'b0; d = 8'h00; mode = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        chk("rst_we", we, 0);
        chk("rst_addr", addr, 0);
        chk("rst_dout", dout, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_line_err", line_err, 0);
        rst = 1'b0;
        idle(3);

        // Two settle frames are discarded, the third is stored.
        repeat (3) full_frame();

        // Directed pixels, overlong line, short lines, empty href pulse, overlong frame.
        do_sof();
        href = 1'b1; d = 8'hF8; mode = 1'b0;
        tick();
        chk("we_after_first_byte", we, 0);
        d = 8'h1F;
        tick();
        m_pixel(8'hF8, 8'h1F, 1'b0);
        chk("we_latency", we, 1);
        chk("rgb_pair", dout, 16'hF81F);
        chk("rgb_pair_swap", dout_s, 16'h1FF8);
        send_pix(8'hFF, 8'($urandom), 1'b1);
        chk("grey_ff", dout, 16'hFFFF);
        send_pix(8'h80, 8'($urandom), 1'b1);
        chk("grey_80", dout, 16'h8410);
        chk("grey_80_swap", dout_s, 16'h8410);
        send_line(H + 2, 1'b0);
        send_line(3, 1'b0);
        send_line(0, 1'b1);
        send_line(5, 1'b1);
        for (int l = 0; l < V; l++) send_line(H, 1'b0);
        do_eof();

        // Aborted frame: vsync rises after three lines.
        do_sof();
        for (int l = 0; l < 3; l++) send_line(H, 1'b0);
        do_eof();

        repeat (3) rand_frame();

        // Asynchronous reset in the middle of a line.
        do_sof();
        send_line(H, 1'b0);
        href = 1'b1; d = 8'h5A; mode = 1'b0;
        tick();
        d = 8'hA5;
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_we", we, 0);
        chk("async_rst_addr", addr, 0);
        chk("async_rst_dout", dout, 0);
        chk("async_rst_frame_cnt", frame_cnt, 0);
        chk("async_rst_line_err", line_err, 0);
        chk("async_rst_frame_done", frame_done, 0);
        got_q.delete(); gots_q.delete(); exp_q.delete(); exps_q.delete();
        got_done = 0; got_done_s = 0;
        m_reset();
        href = 1'b0; vsync = 1'b1;
        repeat (2) @(posedge pclk);
        #1;
        rst = 1'b0;
        idle(3);
        repeat (3) full_frame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
